// File: rtl/field_line_clear_pkg.sv
// Shared playfield geometry, scan FSM encoding and cell-index helper for the
// line-clear block and its row shifter.
package field_line_clear_pkg;

  localparam int FIELD_W = 20;
  localparam int FIELD_H = 20;
  localparam int FIELD_N = FIELD_W * FIELD_H;
  localparam int CNT_W   = $clog2(FIELD_H + 1);
  localparam int ROW_W   = $clog2(FIELD_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Flat bit index of cell (x,y); row y occupies bits [y*FIELD_W +: FIELD_W].
  function automatic int cell_idx(input int y, input int x);
    return y * FIELD_W + x;
  endfunction

endpackage

// File: rtl/field_line_clear_row_shifter.sv
// Combinational helper: reports whether row i_row is full and builds the field
// with rows 0..i_row moved down by one (row 0 cleared).
module field_line_clear_row_shifter
  import field_line_clear_pkg::*;
(
  input  logic [FIELD_N-1:0] i_work,
  input  logic [ROW_W-1:0]   i_row,
  output logic               o_row_full,
  output logic [FIELD_N-1:0] o_shifted
);

  localparam int ROW_SEL_N = 1 << ROW_W;

  logic [FIELD_H-1:0]   w_row_full;
  logic [ROW_SEL_N-1:0] w_full_pad;

  for (genvar k = 0; k < FIELD_H; k++) begin : g_row
    assign w_row_full[k] = &i_work[cell_idx(k, 0) +: FIELD_W];

    // Row 0 is always at or above the pointer, so it always becomes empty.
    if (k == 0) begin : g_top
      assign o_shifted[cell_idx(0, 0) +: FIELD_W] = {FIELD_W{1'b0}};
    end else begin : g_body
      assign o_shifted[cell_idx(k, 0) +: FIELD_W] =
        (ROW_W'(k) <= i_row) ? i_work[cell_idx(k - 1, 0) +: FIELD_W]
                             : i_work[cell_idx(k, 0) +: FIELD_W];
    end
  end

  // Pad to a power of two so an out-of-range pointer reads as "not full".
  assign w_full_pad = {{(ROW_SEL_N - FIELD_H){1'b0}}, w_row_full};
  assign o_row_full = w_full_pad[i_row];

endmodule

// File: rtl/field_line_clear.sv
// Line-clear scanner: walks the locked playfield bottom-up one row per cycle,
// collapsing each full row, then reports the compacted field and clear count.
module field_line_clear
  import field_line_clear_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIELD_N-1:0] field_in,
  output logic               busy,
  output logic               done,
  output logic [FIELD_N-1:0] field_out,
  output logic [CNT_W-1:0]   lines_cleared
);

  state_e             r_state;
  logic [FIELD_N-1:0] r_work;
  logic [ROW_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [FIELD_N-1:0] r_field_out;
  logic [CNT_W-1:0]   r_lines;

  logic               w_row_full;
  logic [FIELD_N-1:0] w_shifted;

  field_line_clear_row_shifter u_shifter (
    .i_work     (r_work),
    .i_row      (r_row),
    .o_row_full (w_row_full),
    .o_shifted  (w_shifted)
  );

  // Scan FSM; busy/done/results are registered alongside the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= {FIELD_N{1'b0}};
      r_row       <= {ROW_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_field_out <= {FIELD_N{1'b0}};
      r_lines     <= {CNT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= field_in;
            r_row   <= ROW_W'(FIELD_H - 1);
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_row_full) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_SHIFT;
          end else if (r_row == {ROW_W{1'b0}}) begin
            r_done      <= 1'b1;
            r_field_out <= r_work;
            r_lines     <= r_cnt;
            r_state     <= ST_DONE;
          end else begin
            r_row   <= r_row - ROW_W'(1);
            r_state <= ST_CHECK;
          end
        end
        // Pointer stays put so the row that just dropped into it is re-tested.
        ST_SHIFT: begin
          r_work  <= w_shifted;
          r_state <= ST_CHECK;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign field_out     = r_field_out;
  assign lines_cleared = r_lines;

endmodule

// File: tb/tb_field_line_clear.sv
// Self-checking bench for field_line_clear: directed boundary fields, random
// fields against a row-compaction model, reset abort and start handshake.
module tb_field_line_clear;

  localparam int W = 20;
  localparam int H = 20;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] field_in;
  logic         busy;
  logic         done;
  logic [N-1:0] field_out;
  logic [4:0]   lines_cleared;

  int errors = 0;
  int checks = 0;

  field_line_clear dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .field_in      (field_in),
    .busy          (busy),
    .done          (done),
    .field_out     (field_out),
    .lines_cleared (lines_cleared)
  );

  always #5 clk = ~clk;

  // Reference: keep non-full rows in order, stacked against the bottom.
  function automatic void model(input logic [N-1:0] f, output logic [N-1:0] o, output int n);
    int dst;
    logic [W-1:0] row;
    o = '0;
    n = 0;
    dst = H - 1;
    for (int y = H - 1; y >= 0; y--) begin
      row = f[y*W +: W];
      if (&row) n++;
      else begin
        o[dst*W +: W] = row;
        dst--;
      end
    end
  endfunction

  function automatic logic [N-1:0] rand_field();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  function automatic logic [N-1:0] rand_with_lines();
    logic [N-1:0] f;
    f = rand_field();
    for (int y = 0; y < H; y++)
      if ($urandom_range(0, 2) == 0) f[y*W +: W] = {W{1'b1}};
    return f;
  endfunction

  // Stimulus only: launch one scan, return what the DUT reported and when.
  task automatic do_scan(input logic [N-1:0] f, output logic [N-1:0] fo,
                         output int lc, output int cyc);
    @(negedge clk);
    start = 1'b1;
    field_in = f;
    @(negedge clk);
    start = 1'b0;
    field_in = rand_field();
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
    fo = field_out;
    lc = int'(lines_cleared);
  endtask

  task automatic test_reset_state();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if (field_out !== '0 || lines_cleared !== 5'd0) begin
      errors++;
      $display("FAIL reset_out: lines=%0d field_out nonzero=%b required 0", lines_cleared, |field_out);
    end
  endtask

  task automatic test_empty();
    logic [N-1:0] fo; int lc, cyc;
    do_scan('0, fo, lc, cyc);
    checks++;
    if (cyc !== 21) begin errors++; $display("FAIL empty_latency: got %0d required 21", cyc); end
    checks++;
    if (lc !== 0 || fo !== '0) begin errors++; $display("FAIL empty_result: lines=%0d required 0", lc); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] f, exp, fo; int lc, cyc;
    f = '0;
    f[19*W +: W] = {W{1'b1}};
    f[18*W + 3] = 1'b1;
    exp = '0;
    exp[19*W + 3] = 1'b1;
    do_scan(f, fo, lc, cyc);
    checks++;
    if (cyc !== 23) begin errors++; $display("FAIL single_latency: got %0d required 23", cyc); end
    checks++;
    if (lc !== 1) begin errors++; $display("FAIL single_lines: got %0d required 1", lc); end
    checks++;
    if (fo !== exp) begin errors++; $display("FAIL single_field: got %h required %h", fo, exp); end
  endtask

  task automatic test_nonadjacent();
    logic [N-1:0] f, exp, fo; int lc, cyc;
    f = '0;
    f[19*W +: W] = {W{1'b1}};
    f[17*W +: W] = {W{1'b1}};
    f[18*W + 0] = 1'b1;
    f[16*W + 5] = 1'b1;
    exp = '0;
    exp[19*W + 0] = 1'b1;
    exp[18*W + 5] = 1'b1;
    do_scan(f, fo, lc, cyc);
    checks++;
    if (cyc !== 25) begin errors++; $display("FAIL nonadj_latency: got %0d required 25", cyc); end
    checks++;
    if (lc !== 2) begin errors++; $display("FAIL nonadj_lines: got %0d required 2", lc); end
    checks++;
    if (fo !== exp) begin errors++; $display("FAIL nonadj_field: got %h required %h", fo, exp); end
  endtask

  task automatic test_full();
    logic [N-1:0] fo; int lc, cyc;
    do_scan({N{1'b1}}, fo, lc, cyc);
    checks++;
    if (cyc !== 61) begin errors++; $display("FAIL full_latency: got %0d required 61", cyc); end
    checks++;
    if (lc !== 20 || fo !== '0) begin
      errors++; $display("FAIL full_result: lines=%0d field nonzero=%b required 20 and 0", lc, |fo);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f, exp, fo; int n, lc, cyc;
    for (int t = 0; t < 12; t++) begin
      f = rand_with_lines();
      if (t == 0) f[0 +: W] = {W{1'b1}};
      model(f, exp, n);
      do_scan(f, fo, lc, cyc);
      checks++;
      if (cyc !== 21 + 2*n || lc !== n || fo !== exp) begin
        errors++;
        $display("FAIL random_%0d: cyc=%0d lines=%0d got %h required cyc=%0d lines=%0d %h",
                 t, cyc, lc, fo, 21 + 2*n, n, exp);
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic [N-1:0] f, fo; int lc, cyc, dones;
    f = '0;
    f[19*W +: W] = {W{1'b1}};
    f[18*W + 7] = 1'b1;
    do_scan(f, fo, lc, cyc);
    @(negedge clk);
    start = 1'b1;
    field_in = {N{1'b1}};
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || field_out !== '0 || lines_cleared !== 5'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b lines=%0d field nonzero=%b required 0", busy, lines_cleared, |field_out);
    end
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_nodone: got %0d pulses required 0", dones); end
  endtask

  task automatic test_handshake();
    logic [N-1:0] fa, fb, fc, ea, ec, o1, o2;
    int na, nc, da, dc, dones, d1, d2, l1, l2;
    fa = rand_with_lines();
    fb = rand_with_lines();
    fc = rand_with_lines();
    model(fa, ea, na);
    model(fc, ec, nc);
    da = 21 + 2*na;
    dc = da + 22 + 2*nc;
    dones = 0; d1 = -1; d2 = -1; l1 = -1; l2 = -1; o1 = '0; o2 = '0;
    @(negedge clk);
    start = 1'b1;
    field_in = fa;
    for (int c = 1; c <= dc + 30; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin d1 = c; o1 = field_out; l1 = int'(lines_cleared); end
        else if (dones == 2) begin d2 = c; o2 = field_out; l2 = int'(lines_cleared); start = 1'b0; end
      end
      if (c == 1) begin start = 1'b0; field_in = fb; end
      else if (c == 3) start = 1'b1;
      else if (c == 4) start = 1'b0;
      else if (c == 10) begin start = 1'b1; field_in = fc; end
    end
    start = 1'b0;
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL hs_pulses: got %0d required 2", dones); end
    checks++;
    if (d1 !== da || l1 !== na || o1 !== ea) begin
      errors++; $display("FAIL hs_first: cyc=%0d lines=%0d required cyc=%0d lines=%0d", d1, l1, da, na);
    end
    checks++;
    if (d2 !== dc || l2 !== nc || o2 !== ec) begin
      errors++; $display("FAIL hs_second: cyc=%0d lines=%0d required cyc=%0d lines=%0d", d2, l2, dc, nc);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    field_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset_state();
    test_empty();
    test_single();
    test_nonadjacent();
    test_full();
    test_random();
    test_reset_midscan();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
